multicycle_seq: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: steps each instruction through

---
 rtl/multicycle_seq_pkg.sv | 24 ++
 rtl/multicycle_seq_op_class.sv | 27 ++
 rtl/multicycle_seq.sv | 122 ++++++++++++
 tb/tb_multicycle_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer and the decoder:
// FSM state codes and the major opcode values.
package multicycle_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE   = 7'b0110011;
    localparam logic [6:0] OP_ITYPE_R = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;

endpackage

// File: rtl/multicycle_seq_op_class.sv
// Combinational opcode classifier: which opcodes are legal and which need
// the memory stage or the early branch exit.
module seq_op_class
    import multicycle_seq_pkg::*;
(
    input  logic [6:0] op,
    output logic       legal,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch
);

    always_comb begin
        legal     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        case (op)
            OP_RTYPE, OP_ITYPE_R, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            OP_LOAD:   begin legal = 1'b1; is_load   = 1'b1; end
            OP_STORE:  begin legal = 1'b1; is_store  = 1'b1; end
            OP_BRANCH: begin legal = 1'b1; is_branch = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/
// MEM/WB, drives memory handshakes, traps on illegal ops or ack timeout.
module multicycle_seq
    import multicycle_seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       Op,
    input  logic             halt,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             busy,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);

    state_t            st, st_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              legal, is_load, is_store, is_branch;
    logic              fetch_req;

    seq_op_class u_op_class (
        .op        (Op),
        .legal     (legal),
        .is_load   (is_load),
        .is_store  (is_store),
        .is_branch (is_branch)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= S_FETCH;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            st       <= st_nxt;
            wait_cnt <= wait_nxt;
            if (pc_we) instret <= instret + 1'b1;
        end
    end

    // Wait counter defaults to zero, so it is already clear on entry to
    // FETCH/MEM and only advances while a req is waiting for its ack.
    always_comb begin
        st_nxt    = st;
        wait_nxt  = '0;
        fetch_req = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        case (st)
            S_FETCH: begin
                fetch_req = ~halt;
                if (fetch_req) begin
                    if (imem_ack) begin
                        ir_we  = 1'b1;
                        st_nxt = S_DECODE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        st_nxt = S_TRAP;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            S_DECODE: st_nxt = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_branch) begin
                    pc_we  = 1'b1;
                    st_nxt = S_FETCH;
                end else if (is_load || is_store) begin
                    st_nxt = S_MEM;
                end else begin
                    st_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_we  = 1'b1;
                        st_nxt = S_FETCH;
                    end else begin
                        st_nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    st_nxt = S_TRAP;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                st_nxt = S_FETCH;
            end
            S_TRAP:  st_nxt = S_TRAP;
            default: st_nxt = S_TRAP;
        endcase
    end

    assign imem_req = fetch_req;
    assign trap     = (st == S_TRAP);
    assign busy     = ~((st == S_FETCH) && halt);
    assign state    = st;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq with a scoreboard of per-instruction
// expectations (latency, enables, handshake length, retire count).
module tb_multicycle_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic [6:0]  Op;
    logic        halt, imem_ack, dmem_ack;
    logic        imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we, busy, trap;
    logic [2:0]  state;
    logic [31:0] instret;

    int pass_cnt = 0;
    int total_cnt = 0;
    int model_instret = 0;

    typedef struct {
        int lat;
        bit rf;
        bit dwe;
        int dreq;
        int instret;
    } exp_t;
    exp_t sb[$];

    multicycle_seq #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .halt(halt),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .busy(busy),
        .trap(trap), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Holds reset across two edges and releases it just after a posedge so
    // the following negedge is the first FETCH cycle.
    task automatic do_reset();
        rstn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        model_instret = 0;
    endtask

    // Model: push expected behaviour for one instruction.
    task automatic push_exp(input logic [6:0] op, input int n);
        exp_t e;
        e.rf = 1'b0; e.dwe = 1'b0; e.dreq = 0;
        case (op)
            7'b1100011: e.lat = 3;
            7'b0000011: begin e.lat = 4 + n; e.rf = 1'b1; e.dreq = n; end
            7'b0100011: begin e.lat = 3 + n; e.dwe = 1'b1; e.dreq = n; end
            default:    begin e.lat = 4; e.rf = 1'b1; end
        endcase
        model_instret++;
        e.instret = model_instret;
        sb.push_back(e);
    endtask

    // Runs one instruction from FETCH with imem_ack held high; dmem_ack is
    // given on the n-th data request cycle. Pops and compares on retire.
    task automatic run_instr(input string name, input logic [6:0] op, input int n);
        exp_t e;
        int cyc = 0, dreq = 0, lat = -1, irc = -1;
        bit rf = 1'b0, dwe = 1'b0;
        push_exp(op, n);
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            Op = op; imem_ack = 1'b1;
            if (dmem_req) begin dreq++; dmem_ack = (dreq == n); end
            else dmem_ack = 1'b0;
            #1;
            cyc++;
            if (ir_we && irc < 0) irc = cyc;
            if (rf_we) rf = 1'b1;
            if (dmem_we) dwe = 1'b1;
            if (pc_we) lat = cyc;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        e = sb.pop_front();
        chk({name, "_latency"}, lat, e.lat);
        chk({name, "_ir_we_cycle"}, irc, 1);
        chk({name, "_rf_we"}, {31'd0, rf}, {31'd0, e.rf});
        chk({name, "_dmem_we"}, {31'd0, dwe}, {31'd0, e.dwe});
        chk({name, "_dmem_req_cycles"}, dreq, e.dreq);
        chk({name, "_instret"}, instret, e.instret);
    endtask

    initial begin
        logic any_en;
        Op = 7'd0; halt = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        rstn = 1'b0;
        #2;
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_trap", {31'd0, trap}, 0);
        chk("rst_instret", instret, 0);
        chk("rst_busy", {31'd0, busy}, 1);
        chk("rst_dmem_req", {31'd0, dmem_req}, 0);
        do_reset();

        run_instr("rtype", 7'b0110011, 1);
        run_instr("load", 7'b0000011, 3);
        run_instr("store", 7'b0100011, 1);
        run_instr("branch", 7'b1100011, 1);
        run_instr("jal", 7'b1101111, 1);
        run_instr("lui", 7'b0110111, 1);
        run_instr("store_slow", 7'b0100011, 2);
        run_instr("load_fast", 7'b0000011, 1);

        // Illegal opcode
        @(negedge clk); Op = 7'b1111111; imem_ack = 1'b1; #1;
        @(negedge clk); #1;
        chk("ill_decode_state", {29'd0, state}, 1);
        chk("ill_decode_trap", {31'd0, trap}, 0);
        @(negedge clk); #1;
        chk("ill_trap", {31'd0, trap}, 1);
        chk("ill_state", {29'd0, state}, 7);
        any_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); dmem_ack = 1'b1; #1;
            any_en |= imem_req | dmem_req | dmem_we | pc_we | ir_we | rf_we | ~trap;
        end
        chk("ill_enables_20cyc", {31'd0, any_en}, 0);
        rstn = 1'b0; #1;
        chk("ill_rst_state", {29'd0, state}, 0);
        chk("ill_rst_trap", {31'd0, trap}, 0);
        chk("ill_rst_instret", instret, 0);
        do_reset();

        // Fetch timeout: 16 unanswered req cycles
        Op = 7'b0110011;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); imem_ack = 1'b0; #1;
            if (i == 1) chk("to_req_first", {31'd0, imem_req}, 1);
            if (i == 16) begin
                chk("to_req_last", {31'd0, imem_req}, 1);
                chk("to_no_trap_yet", {31'd0, trap}, 0);
            end
        end
        @(negedge clk); #1;
        chk("to_trap", {31'd0, trap}, 1);
        chk("to_imem_req_off", {31'd0, imem_req}, 0);
        do_reset();

        // Ack on the last allowed req cycle wins
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); imem_ack = (i == 16); #1;
            if (i == 16) chk("to_ack_ir_we", {31'd0, ir_we}, 1);
        end
        @(negedge clk); imem_ack = 1'b0; #1;
        chk("to_ack_state", {29'd0, state}, 1);
        chk("to_ack_trap", {31'd0, trap}, 0);
        do_reset();

        // Halt during EXEC
        Op = 7'b0110011;
        @(negedge clk); imem_ack = 1'b1; #1;
        @(negedge clk); #1;
        @(negedge clk); halt = 1'b1; #1;
        chk("halt_exec_state", {29'd0, state}, 2);
        chk("halt_exec_busy", {31'd0, busy}, 1);
        @(negedge clk); #1;
        chk("halt_wb_pc_we", {31'd0, pc_we}, 1);
        chk("halt_wb_rf_we", {31'd0, rf_we}, 1);
        @(negedge clk); #1;
        chk("halt_imem_req", {31'd0, imem_req}, 0);
        chk("halt_busy", {31'd0, busy}, 0);
        chk("halt_ack_ignored", {31'd0, ir_we}, 0);
        @(negedge clk); #1;
        chk("halt_hold_state", {29'd0, state}, 0);
        chk("halt_instret", instret, 1);
        halt = 1'b0; Op = 7'b0000011; #1;
        chk("unhalt_imem_req", {31'd0, imem_req}, 1);
        chk("unhalt_busy", {31'd0, busy}, 1);

        // Async reset mid-MEM
        @(negedge clk); dmem_ack = 1'b0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("mem_dmem_req", {31'd0, dmem_req}, 1);
        chk("mem_dmem_we", {31'd0, dmem_we}, 0);
        rstn = 1'b0; #1;
        chk("arst_dmem_req", {31'd0, dmem_req}, 0);
        chk("arst_state", {29'd0, state}, 0);
        do_reset();

        run_instr("post_rst_rtype", 7'b0010011, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
